aer_tx: RTL

- Read-side consumer for the spike event FIFO in the Poisson neuron array.
- Pops spike addresses from the FIFO and transmits each one off-block as an Address-Event Representation (AER) word.
- Uses a 4-phase req/ack handshake; ack is asynchronous and is synchronised internally.
- Provides an event counter and an ack-timeout error flag for debug and readout.

---
 rtl/aer_tx_if.sv | 12 +
 rtl/aer_tx.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/aer_tx_if.sv
// AER link bundle: address bus, request and asynchronous acknowledge.
// The transmitter drives addr/req (master); the off-block receiver answers on ack (slave).
interface aer_tx_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] addr;
    logic                  req;
    logic                  ack;

    modport master (output addr, output req, input ack);
    modport slave  (input addr, input req, output ack);
endinterface

// File: rtl/aer_tx.sv
// Spike-FIFO reader that ships each popped address over a 4-phase AER req/ack link,
// with ack synchronisation, per-phase ack timeout and a completed-event counter.
module aer_tx #(
    parameter int DATA_WIDTH     = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int SETUP_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd,
    aer_tx_if.master              aer,
    output logic                  busy,
    output logic                  timeout_err,
    input  logic                  clr_err,
    output logic [CNT_WIDTH-1:0]  event_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        REQ     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int WAIT_MAX = (TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES;
    localparam int WCW      = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam bit TO_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [WCW-1:0] SETUP_LAST = WCW'(SETUP_CYCLES - 1);
    localparam logic [WCW-1:0] TO_LAST    = TO_EN ? WCW'(TIMEOUT_CYCLES - 1) : {WCW{1'b0}};
    localparam logic [WCW-1:0] WAIT_SAT   = {WCW{1'b1}};
    localparam logic [WCW-1:0] WAIT_ONE   = WCW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] ack_sync_r;
    logic                   ack_s;
    state_t                 state_r, state_s;
    logic [WCW-1:0]         wait_cnt_r, wait_cnt_s;
    logic                   timed_out_r, timed_out_s;
    logic                   timeout_s, done_s, fifo_rd_s;
    logic                   aer_req_r, aer_req_s;
    logic [DATA_WIDTH-1:0]  aer_addr_r, aer_addr_s;
    logic                   busy_r, busy_s;
    logic                   timeout_err_r, timeout_err_s;
    logic [CNT_WIDTH-1:0]   event_count_r, event_count_s;

    assign ack_s     = ack_sync_r[SYNC_STAGES-1];
    assign fifo_rd_s = (state_r == IDLE) & enable & ~fifo_empty & ~ack_s;

    assign fifo_rd     = fifo_rd_s;
    assign aer.addr    = aer_addr_r;
    assign aer.req     = aer_req_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_err_r;
    assign event_count = event_count_r;

    // Bring the receiver's asynchronous ack into the clk domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            ack_sync_r <= {ack_sync_r[SYNC_STAGES-2:0], aer.ack};
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            wait_cnt_r    <= {WCW{1'b0}};
            timed_out_r   <= 1'b0;
            aer_req_r     <= 1'b0;
            aer_addr_r    <= {DATA_WIDTH{1'b0}};
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
            event_count_r <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r       <= state_s;
            wait_cnt_r    <= wait_cnt_s;
            timed_out_r   <= timed_out_s;
            aer_req_r     <= aer_req_s;
            aer_addr_r    <= aer_addr_s;
            busy_r        <= busy_s;
            timeout_err_r <= timeout_err_s;
            event_count_r <= event_count_s;
        end
    end

    // Next-state logic; an ack that arrives on the last waiting cycle beats the timeout.
    always_comb begin
        state_s   = state_r;
        timeout_s = 1'b0;
        done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (fifo_rd_s) state_s = SETUP;
                else           state_s = IDLE;
            end
            SETUP: begin
                if (wait_cnt_r >= SETUP_LAST) state_s = REQ;
                else                          state_s = SETUP;
            end
            REQ: begin
                if (ack_s) begin
                    state_s = RELEASE;
                end else if (TO_EN && (wait_cnt_r == TO_LAST)) begin
                    state_s   = RELEASE;
                    timeout_s = 1'b1;
                end else begin
                    state_s = REQ;
                end
            end
            RELEASE: begin
                if (!ack_s) begin
                    state_s = IDLE;
                    done_s  = ~timed_out_r;
                end else if (TO_EN && (wait_cnt_r == TO_LAST)) begin
                    state_s   = IDLE;
                    timeout_s = 1'b1;
                end else begin
                    state_s = RELEASE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs, wait counter and error bookkeeping.
    always_comb begin
        aer_req_s = (state_s == REQ);
        busy_s    = (state_s != IDLE);

        if (fifo_rd_s) aer_addr_s = fifo_data;
        else           aer_addr_s = aer_addr_r;

        if (state_s != state_r)        wait_cnt_s = {WCW{1'b0}};
        else if (wait_cnt_r != WAIT_SAT) wait_cnt_s = wait_cnt_r + WAIT_ONE;
        else                           wait_cnt_s = wait_cnt_r;

        // A request-phase timeout marks the event so the release exit does not count it.
        if (state_r == IDLE)                  timed_out_s = 1'b0;
        else if (timeout_s && (state_r == REQ)) timed_out_s = 1'b1;
        else                                  timed_out_s = timed_out_r;

        if (timeout_s)    timeout_err_s = 1'b1;
        else if (clr_err) timeout_err_s = 1'b0;
        else              timeout_err_s = timeout_err_r;

        if (done_s) event_count_s = event_count_r + CNT_ONE;
        else        event_count_s = event_count_r;
    end

endmodule
